// File: rtl/lfsr_gen.sv
//==============================================================================
// Module   : lfsr_gen
// Brief    : XNOR Fibonacci LFSR with seed load, clock enable, extended
//            2^WIDTH mode and done/lock-up flags. Define LFSR_PERIOD_CNT_EN
//            to add the step_cnt/wrap period counter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module lfsr_gen #(
  parameter int unsigned      WIDTH      = 13,
  parameter logic [WIDTH-1:0] TAPS       = 13'h100D,
  parameter logic [WIDTH-1:0] RESET_SEED = '0,
  parameter logic [WIDTH-1:0] DONE_VAL   = 13'h0220
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             ext_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] lfsr,
  output logic             lfsr_done,
  output logic             lockup
`ifdef LFSR_PERIOD_CNT_EN
  ,
  output logic [WIDTH:0]   step_cnt,
  output logic             wrap
`endif
);

  localparam logic [WIDTH-1:0] c_all_ones  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_pre_ones  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_post_ones = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [WIDTH-1:0] r_lfsr;
  logic             r_done;
  logic             w_fb;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_next;

  assign w_fb    = ~^(r_lfsr & TAPS);
  assign w_shift = {r_lfsr[WIDTH-2:0], w_fb};

  // Extended mode splices all-ones between 0111..1 and its normal successor.
  always_comb begin
    w_next = w_shift;
    if (ext_mode) begin
      if (r_lfsr == c_pre_ones) begin
        w_next = c_all_ones;
      end else if (r_lfsr == c_all_ones) begin
        w_next = c_post_ones;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= RESET_SEED;
      r_done <= 1'b0;
    end else if (load) begin
      r_lfsr <= seed;
      r_done <= 1'b0;
    end else if (ce) begin
      r_lfsr <= w_next;
      r_done <= (r_lfsr == DONE_VAL);
    end else begin
      r_done <= 1'b0;
    end
  end

  assign lfsr      = r_lfsr;
  assign lfsr_done = r_done;
  assign lockup    = (r_lfsr == c_all_ones) && !ext_mode;

`ifdef LFSR_PERIOD_CNT_EN
  localparam logic [WIDTH:0] c_cnt_one = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_start;
  logic [WIDTH:0]   r_cnt;
  logic             r_wrap;
  logic             r_restart;
  logic             w_hit;

  assign w_hit = (w_next == r_start);

  // After a wrap the count shows the period until the next step restarts it at 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start   <= RESET_SEED;
      r_cnt     <= '0;
      r_wrap    <= 1'b0;
      r_restart <= 1'b0;
    end else if (load) begin
      r_start   <= seed;
      r_cnt     <= '0;
      r_wrap    <= 1'b0;
      r_restart <= 1'b0;
    end else if (ce) begin
      r_cnt     <= r_restart ? c_cnt_one : r_cnt + c_cnt_one;
      r_wrap    <= w_hit;
      r_restart <= w_hit;
    end else begin
      r_wrap    <= 1'b0;
    end
  end

  assign step_cnt = r_cnt;
  assign wrap     = r_wrap;
`endif

endmodule

`default_nettype wire
